fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end feeding the IF/ID pipeline register.
- Owns the PC and issues sequential word fetches to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small prefetch FIFO and presents {pc, instruction, pc+4} to decode.
- Handles stall from ID and redirect from EX (branch/jal/jalr), discarding stale in-flight fetches.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, >=2; also the cap on requests in flight.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = in reset).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_resp_valid  in  1  response data valid; one per accepted request, in order, latency >=1, never backpressured.
- imem_resp_data  in  XLEN  fetched instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).
- stall  in  1  ID cannot accept this cycle.
- if_valid  out  1  FIFO head valid.
- if_pc  out  XLEN  PC of head instruction.
- if_instruction  out  XLEN  head instruction.
- if_pc_plus_4  out  XLEN  if_pc + 4.

Behaviour:
- Reset (rst=0): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: imem_req_valid=0, if_valid=0, if_pc/if_instruction=0, if_pc_plus_4=4.
- Memory shares the same reset. Responses for pre-reset requests never arrive.
- Request issue:
  - imem_req_valid = !redirect_valid && (fifo_count + outstanding) < FIFO_DEPTH, using registered counts only. A same-cycle pop gives no credit.
  - imem_req_addr = fetch_pc.
  - Accept = valid && ready. On accept, fetch_pc += 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
  - While valid && !ready, address and valid are held stable, except that a redirect may withdraw or change them.
- outstanding_next = outstanding + accept - imem_resp_valid. This count includes stale requests.
- Response handling:
  - If drop_cnt>0: discard the response, drop_cnt--.
  - Otherwise push {resp_pc, imem_resp_data} into the FIFO and set resp_pc += 4.
  - Overflow is impossible by the credit rule. Assert on push to a full FIFO.
- Output:
  - if_valid = FIFO not empty; outputs show the head entry.
  - Pop when if_valid && !stall && !redirect_valid.
  - Simultaneous push and pop are allowed at any occupancy.
  - No bypass: an instruction appears on if_* no earlier than the cycle after its resp_valid.
- Redirect (redirect_valid=1), which has priority over all else in that cycle:
  - FIFO flushed; if_valid=0 next cycle.
  - fetch_pc and resp_pc set to {redirect_pc[XLEN-1:2],2'b00}.
  - No request issued that cycle.
  - drop_cnt_next = outstanding - imem_resp_valid, and any response in that cycle is discarded.
  - Any pending pop and push are cancelled.
- Back-to-back redirects: each recomputes drop_cnt from current outstanding. The last redirect wins.
- Redirect while drop_cnt>0: same formula; the older stale responses are covered because outstanding includes them.
- Steady-state throughput: with 1-cycle memory, always-ready, and no stall, one instruction per cycle after a 2-cycle fill latency from reset release: request in cycle 0, resp in cycle 1, if_valid in cycle 2.
- Stall held indefinitely: FIFO fills to FIFO_DEPTH, then requests stop. Nothing is lost or duplicated.

Decomposition:
- riscv_pkg: XLEN, ILEN, RESET_PC default, NOP encoding 32'h0000_0013 for benches, and the typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full. Same clk/rst.
- fetch_unit holds the PC counters, outstanding/drop counters and issue logic. Target size is about 200 lines total.

Test Plan:
- Reset release, 1-cycle always-ready memory returning addr>>2, no stall -> requests to 0x0,0x4,0x8,... on consecutive cycles; if_valid rises 2 cycles after release; if_pc=0x0,0x4,... each cycle; if_instruction=0,1,2.
- Stall held 10 cycles at FIFO_DEPTH=2 -> exactly 2 entries buffered, imem_req_valid=0, no loss. Release stall -> contiguous PCs resume with no gap or duplicate.
- imem_req_ready low 3 cycles while imem_req_addr=0x10 -> address is held at 0x10; fetch_pc advances only on the accept cycle.
- 3-cycle memory latency with 2 requests in flight, redirect_pc=0x100 -> both stale responses dropped; first if_pc=0x100 with the data fetched from 0x100.
- Redirect in the same cycle as imem_resp_valid and a pop -> that response is discarded, drop_cnt = outstanding-1, and nothing is popped or pushed.
- Redirect to 0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap). Redirect_pc=0x103 -> fetches 0x100. Assert rst=0 mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch front end.
//   XLEN/ILEN     : address and instruction widths
//   RESET_PC      : default PC loaded on reset
//   NOP           : canonical addi x0,x0,0 encoding (used as idle filler by benches)
//   fetch_entry_t : one prefetch-buffer entry {pc, instr}
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [ILEN-1:0] NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched instructions and their PCs.
//   clk, rst   : clock, asynchronous active-low reset
//   push/entry : write one entry at the tail
//   pop        : drop the head entry (caller guarantees not empty)
//   flush      : empty the FIFO; overrides push and pop
//   head       : current head entry (undefined when empty)
//   count      : occupancy, empty/full flags
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  fetch_entry_t               entry,
   input  logic                       pop,
   input  logic                       flush,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; validity is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_q] <= entry;
   end

   assign head  = mem[rd_ptr_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential word fetches over a
// valid/ready channel with in-order responses, buffers them and feeds IF/ID.
//   clk, rst               : clock, asynchronous active-low reset
//   imem_req_valid/ready   : fetch request handshake
//   imem_req_addr          : word-aligned fetch address
//   imem_resp_valid/data   : in-order fetch responses, never backpressured
//   redirect_valid/pc      : flush and restart fetch at redirect_pc (low 2 bits ignored)
//   stall                  : ID cannot accept this cycle
//   if_valid/pc/instruction/pc_plus_4 : head of the prefetch FIFO
module fetch_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instruction,
   output logic [XLEN-1:0] if_pc_plus_4
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty, fifo_full;
   logic [CNT_W:0]   credit_used;
   logic             accept, drop_resp, push, pop;
   logic [XLEN-1:0]  redirect_aligned;

   riscv_pkg::fetch_entry_t push_entry, head;

   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

   // Credit uses registered counts only; a pop this cycle frees nothing until next cycle.
   // Stale in-flight requests still hold credit, so a push can never hit a full FIFO.
   assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign imem_req_valid = rst && !redirect_valid && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   assign drop_resp  = redirect_valid || (drop_cnt_q != '0);
   assign push       = imem_resp_valid && !drop_resp;
   assign pop        = !fifo_empty && !stall && !redirect_valid;
   assign push_entry = '{pc: resp_pc_q, instr: imem_resp_data};

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_resp_valid);
      if (redirect_valid) begin
         fetch_pc_d = redirect_aligned;
         resp_pc_d  = redirect_aligned;
         // Everything still in flight after this cycle's response is stale.
         drop_cnt_d = outstanding_q - CNT_W'(imem_resp_valid);
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (push)   resp_pc_d  = resp_pc_q + XLEN'(4);
         if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .entry (push_entry),
      .pop   (pop),
      .flush (redirect_valid),
      .head  (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Outputs are forced to zero while empty so they are deterministic out of reset.
   assign if_valid       = !fifo_empty;
   assign if_pc          = fifo_empty ? '0 : head.pc;
   assign if_instruction = fifo_empty ? '0 : head.instr;
   assign if_pc_plus_4   = if_pc + XLEN'(4);

   push_not_full: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic [31:0] if_pc_plus_4;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned lat   = 1;
   int unsigned cyc   = 0;
   logic [31:0] exp_pc;
   logic [31:0] got [3];
   int          n_got;
   logic        found;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } pend_t;
   pend_t pend [$];

   fetch_unit #(
      .XLEN       (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .stall           (stall),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_instruction  (if_instruction),
      .if_pc_plus_4    (if_pc_plus_4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory: word at addr holds addr>>2, response 'lat' cycles after accept, in order.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend.delete();
         imem_resp_valid <= 1'b0;
         imem_resp_data  <= NOP;
      end else begin
         if (imem_resp_valid) void'(pend.pop_front());
         if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + lat});
         cyc = cyc + 1;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid <= 1'b1;
            imem_resp_data  <= pend[0].addr >> 2;
         end else begin
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= NOP;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_vec++;
      if (got_v !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
      end
   endtask

   // Consumer model: every pop must deliver the next expected PC and its word.
   task automatic step();
      if (rst) begin
         if (redirect_valid) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
         end else if (if_valid && !stall) begin
            check("pop_pc", if_pc, exp_pc);
            check("pop_instr", if_instruction, exp_pc >> 2);
            check("pop_pc4", if_pc_plus_4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 30 && !if_valid; i++) step();
      check(tag, {31'd0, if_valid}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
      check({pfx, "_req_addr"}, imem_req_addr, 32'h0);
      check({pfx, "_if_valid"}, {31'd0, if_valid}, 32'd0);
      check({pfx, "_if_pc"}, if_pc, 32'h0);
      check({pfx, "_if_instr"}, if_instruction, 32'h0);
      check({pfx, "_if_pc4"}, if_pc_plus_4, 32'h4);
   endtask

   initial begin
      rst            = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      stall          = 1'b0;
      exp_pc         = 32'h0;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst");

      // Fill from reset release.
      rst = 1'b1;
      #1;
      check("c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("c0_req_addr", imem_req_addr, 32'h0);
      check("c0_if_valid", {31'd0, if_valid}, 32'd0);
      step();
      check("c1_req_addr", imem_req_addr, 32'h4);
      check("c1_if_valid", {31'd0, if_valid}, 32'd0);
      step();
      check("c2_if_valid", {31'd0, if_valid}, 32'd1);
      check("c2_if_pc", if_pc, 32'h0);
      repeat (9) step();

      // Long stall: FIFO fills to 2, requests stop, both entries come out afterwards.
      stall = 1'b1;
      repeat (10) step();
      check("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
      check("stall_head", if_pc, exp_pc);
      stall = 1'b0;
      step();
      check("stall_second", {31'd0, if_valid}, 32'd1);
      repeat (6) step();

      // Request held while not ready.
      stall = 1'b1;
      repeat (4) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      imem_req_ready = 1'b0;
      #1;
      check("redir_noreq", {31'd0, imem_req_valid}, 32'd0);
      step();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("hold_valid", {31'd0, imem_req_valid}, 32'd1);
         check("hold_addr", imem_req_addr, 32'h10);
         step();
      end
      imem_req_ready = 1'b1;
      #1;
      check("acc_addr", imem_req_addr, 32'h10);
      step();
      check("adv_addr", imem_req_addr, 32'h14);
      repeat (6) step();

      // 3-cycle memory, redirect with two requests in flight.
      stall = 1'b1;
      repeat (4) step();
      lat            = 3;
      stall          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      #1;
      check("lat_req0", imem_req_addr, 32'h40);
      step();
      check("lat_req1_valid", {31'd0, imem_req_valid}, 32'd1);
      check("lat_req1", imem_req_addr, 32'h44);
      step();
      check("inflight_cap", {31'd0, imem_req_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      step();
      redirect_valid = 1'b0;
      wait_valid("stale_fill");
      check("stale_pc", if_pc, 32'h100);
      check("stale_instr", if_instruction, 32'h40);
      repeat (4) step();

      // Redirect coinciding with a response and a would-be pop.
      lat = 1;
      repeat (6) step();
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (if_valid && imem_resp_valid) found = 1'b1;
         else step();
      end
      check("coincide_found", {31'd0, found}, 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      #1;
      check("coincide_noreq", {31'd0, imem_req_valid}, 32'd0);
      step();
      redirect_valid = 1'b0;
      check("coincide_flush", {31'd0, if_valid}, 32'd0);
      wait_valid("coincide_fill");
      check("coincide_pc", if_pc, 32'h200);
      check("coincide_instr", if_instruction, 32'h80);
      repeat (4) step();

      // Wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      step();
      redirect_valid = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) got[i] = 32'hDEAD_BEEF;
      n_got = 0;
      for (int i = 0; i < 30 && n_got < 3; i++) begin
         if (imem_req_valid && imem_req_ready) begin
            got[n_got] = imem_req_addr;
            n_got++;
         end
         step();
      end
      check("wrap_a0", got[0], 32'hFFFF_FFF8);
      check("wrap_a1", got[1], 32'hFFFF_FFFC);
      check("wrap_a2", got[2], 32'h0000_0000);
      repeat (6) step();

      // Misaligned redirect target is word-aligned.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      step();
      redirect_valid = 1'b0;
      #1;
      got[0] = 32'hDEAD_BEEF;
      for (int i = 0; i < 30; i++) begin
         if (imem_req_valid && imem_req_ready) begin
            got[0] = imem_req_addr;
            break;
         end
         step();
      end
      check("align_addr", got[0], 32'h100);
      wait_valid("align_fill");
      check("align_pc", if_pc, 32'h100);
      repeat (4) step();

      // Asynchronous reset mid-stream, away from any clock edge.
      rst = 1'b0;
      #1;
      check_reset_outputs("async");
      @(negedge clk);
      rst    = 1'b1;
      exp_pc = 32'h0;
      step();
      wait_valid("restart_fill");
      check("restart_pc", if_pc, exp_pc);
      repeat (6) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
